// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin front end for a single 256x32 BlockRAM tile.
// Writes go straight to the write port; reads are tagged so each response returns to its issuer.
module bram_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic [ADDR_W-1:0] bram_rd_addr,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_rd_data,

    output logic              busy
);

    // One tag stage for the read-address register plus one per BRAM latency cycle,
    // so the last stage lines up with valid bram_rd_data.
    localparam int NSTG = READ_LATENCY + 1;

    logic              r_ptr_b;
    logic [NSTG-1:0]   r_tag_v;
    logic [NSTG-1:0]   r_tag_b;

    logic              r_bram_we;
    logic [ADDR_W-1:0] r_bram_wr_addr;
    logic [DATA_W-1:0] r_bram_wr_data;
    logic [ADDR_W-1:0] r_bram_rd_addr;

    logic              r_a_rsp_valid;
    logic [DATA_W-1:0] r_a_rsp_rdata;
    logic              r_b_rsp_valid;
    logic [DATA_W-1:0] r_b_rsp_rdata;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic              w_accept_rd;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_tag_out_a;
    logic              w_tag_out_b;

    // A lone requester always wins; on contention the pointer's owner wins.
    always_comb begin
        w_grant_a   = resetn & a_req_valid & (~b_req_valid | ~r_ptr_b);
        w_grant_b   = resetn & b_req_valid & (~a_req_valid |  r_ptr_b);
        w_accept    = w_grant_a | w_grant_b;
        w_sel_we    = w_grant_b ? b_req_we    : a_req_we;
        w_sel_addr  = w_grant_b ? b_req_addr  : a_req_addr;
        w_sel_wdata = w_grant_b ? b_req_wdata : a_req_wdata;
        w_accept_rd = w_accept & ~w_sel_we;
        w_tag_out_a = r_tag_v[NSTG-1] & ~r_tag_b[NSTG-1];
        w_tag_out_b = r_tag_v[NSTG-1] &  r_tag_b[NSTG-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr_b <= 1'b0;
        end else if (w_accept) begin
            r_ptr_b <= w_grant_a;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bram_we      <= 1'b0;
            r_bram_wr_addr <= '0;
            r_bram_wr_data <= '0;
            r_bram_rd_addr <= '0;
        end else begin
            r_bram_we <= w_accept & w_sel_we;
            if (w_accept & w_sel_we) begin
                r_bram_wr_addr <= w_sel_addr;
                r_bram_wr_data <= w_sel_wdata;
            end
            if (w_accept_rd) begin
                r_bram_rd_addr <= w_sel_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag_v <= '0;
            r_tag_b <= '0;
        end else begin
            r_tag_v <= {r_tag_v[NSTG-2:0], w_accept_rd};
            r_tag_b <= {r_tag_b[NSTG-2:0], w_grant_b};
        end
    end

    // Response data is captured only for the owner, so the other side keeps its last word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_rdata <= '0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_rdata <= '0;
        end else begin
            r_a_rsp_valid <= w_tag_out_a;
            r_b_rsp_valid <= w_tag_out_b;
            if (w_tag_out_a) begin
                r_a_rsp_rdata <= bram_rd_data;
            end
            if (w_tag_out_b) begin
                r_b_rsp_rdata <= bram_rd_data;
            end
        end
    end

    assign a_req_ready  = w_grant_a;
    assign b_req_ready  = w_grant_b;
    assign a_rsp_valid  = r_a_rsp_valid;
    assign a_rsp_rdata  = r_a_rsp_rdata;
    assign b_rsp_valid  = r_b_rsp_valid;
    assign b_rsp_rdata  = r_b_rsp_rdata;
    assign bram_we      = r_bram_we;
    assign bram_wr_addr = r_bram_wr_addr;
    assign bram_wr_data = r_bram_wr_data;
    assign bram_rd_addr = r_bram_rd_addr;
    assign busy         = (|r_tag_v) | r_a_rsp_valid | r_b_rsp_valid;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 256x32 BRAM of latency 2.
module tb_bram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic [AW-1:0] bram_rd_addr, bram_wr_addr;
    logic [DW-1:0] bram_wr_data, bram_rd_data;
    logic          bram_we, busy;

    int n_cmp = 0;
    int n_bad = 0;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .resetn(resetn),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr),
        .bram_wr_data(bram_wr_data), .bram_we(bram_we),
        .bram_rd_data(bram_rd_data), .busy(busy)
    );

    // BRAM model: write on the edge after bram_we, two-stage registered read.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] p1, p2;
    logic          preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | i;
        end else if (bram_we) begin
            mem[bram_wr_addr] <= bram_wr_data;
        end
        p1 <= mem[bram_rd_addr];
        p2 <= p1;
    end
    assign bram_rd_data = p2;

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];
    always @(negedge clk) begin
        if (a_rsp_valid) a_q.push_back(a_rsp_rdata);
        if (b_rsp_valid) b_q.push_back(b_rsp_rdata);
    end

    function automatic logic [DW-1:0] pat(input int a);
        return 32'h5A00_0000 | a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0; preload = 1'b1; a_req_valid = 1'b1;
        step(); step();
        preload = 1'b0;
        #1;
        n_cmp++; if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, bram_we, busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, bram_we, busy}); end
        n_cmp++; if ({a_rsp_rdata, b_rsp_rdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", {a_rsp_rdata, b_rsp_rdata}); end
        n_cmp++; if ({bram_wr_addr, bram_rd_addr, bram_wr_data} !== 48'h0) begin
            n_bad++; $display("FAIL reset_bram: got %h want 0", {bram_wr_addr, bram_rd_addr, bram_wr_data}); end
        a_req_valid = 1'b0;
        resetn = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_alternate();
        int ia = 0, ib = 0;
        logic ga, exp_a;
        a_q.delete(); b_q.delete();
        for (int c = 0; c < 6; c++) begin
            a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'(1 + ia);
            b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'(8'h80 + ib);
            #1;
            exp_a = (c % 2 == 0);
            n_cmp++; if ({a_req_ready, b_req_ready} !== {exp_a, ~exp_a}) begin
                n_bad++; $display("FAIL alt_grant c=%0d: got %b want %b", c, {a_req_ready, b_req_ready}, {exp_a, ~exp_a}); end
            ga = a_req_ready;
            step();
            $display("alt c=%0d grant=%s", c, ga ? "A" : "B");
            if (ga) ia++; else ib++;
        end
        idle_inputs();
        repeat (RL + 3) step();
        n_cmp++; if (a_q.size() != 3 || b_q.size() != 3) begin
            n_bad++; $display("FAIL alt_count: got A=%0d B=%0d want 3/3", a_q.size(), b_q.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < a_q.size()) begin
                n_cmp++; if (a_q[k] !== pat(1 + k)) begin
                    n_bad++; $display("FAIL alt_a_data k=%0d: got %h want %h", k, a_q[k], pat(1 + k)); end
            end
            if (k < b_q.size()) begin
                n_cmp++; if (b_q[k] !== pat(8'h80 + k)) begin
                    n_bad++; $display("FAIL alt_b_data k=%0d: got %h want %h", k, b_q[k], pat(8'h80 + k)); end
            end
        end
    endtask

    task automatic test_write_read();
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h10; a_req_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if ({a_req_ready, b_req_ready} !== 2'b10) begin
            n_bad++; $display("FAIL wr_grant: got %b want 10", {a_req_ready, b_req_ready}); end
        step();
        $display("A write 10 <= deadbeef");
        n_cmp++; if ({bram_we, bram_wr_addr, bram_wr_data} !== {1'b1, 8'h10, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL wr_port: got %h want 110deadbeef", {bram_we, bram_wr_addr, bram_wr_data}); end
        a_req_we = 1'b0;
        #1;
        step();
        $display("A read 10");
        idle_inputs();
        n_cmp++; if ({bram_we, bram_rd_addr} !== {1'b0, 8'h10}) begin
            n_bad++; $display("FAIL rd_port: got %h want 010", {bram_we, bram_rd_addr}); end
        for (int k = 1; k <= RL + 2; k++) begin
            step();
            n_cmp++; if ({a_rsp_valid, b_rsp_valid} !== {(k == RL + 1), 1'b0}) begin
                n_bad++; $display("FAIL rd_latency k=%0d: got %b want %b", k, {a_rsp_valid, b_rsp_valid}, {(k == RL + 1), 1'b0}); end
            if (k == RL + 1) begin
                n_cmp++; if (a_rsp_rdata !== 32'hDEAD_BEEF) begin
                    n_bad++; $display("FAIL rd_data: got %h want deadbeef", a_rsp_rdata); end
            end
        end
    endtask

    task automatic test_raw_top();
        a_q.delete(); b_q.delete();
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 8'hFF; b_req_wdata = 32'h1234_5678;
        #1;
        n_cmp++; if ({a_req_ready, b_req_ready} !== 2'b01) begin
            n_bad++; $display("FAIL raw_wgrant: got %b want 01", {a_req_ready, b_req_ready}); end
        step();
        $display("B write ff <= 12345678");
        idle_inputs();
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'hFF;
        #1;
        n_cmp++; if ({a_req_ready, b_req_ready} !== 2'b10) begin
            n_bad++; $display("FAIL raw_rgrant: got %b want 10", {a_req_ready, b_req_ready}); end
        step();
        $display("A read ff");
        idle_inputs();
        repeat (RL + 3) step();
        n_cmp++; if (a_q.size() != 1 || b_q.size() != 0) begin
            n_bad++; $display("FAIL raw_count: got A=%0d B=%0d want 1/0", a_q.size(), b_q.size()); end
        n_cmp++; if (a_rsp_rdata !== 32'h1234_5678) begin
            n_bad++; $display("FAIL raw_data: got %h want 12345678", a_rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic exp_v, exp_busy;
        for (int t = 0; t < 8 + RL + 4; t++) begin
            if (t < 8) begin
                a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'(t);
            end else begin
                idle_inputs();
            end
            #1;
            if (t < 8) begin
                n_cmp++; if (a_req_ready !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_ready t=%0d: got %b want 1", t, a_req_ready); end
            end
            step();
            exp_v    = (t >= RL + 1) && (t <= RL + 8);
            exp_busy = (t <= RL + 8);
            n_cmp++; if ({a_rsp_valid, busy} !== {exp_v, exp_busy}) begin
                n_bad++; $display("FAIL b2b_vb t=%0d: got %b want %b", t, {a_rsp_valid, busy}, {exp_v, exp_busy}); end
            if (exp_v) begin
                n_cmp++; if (a_rsp_rdata !== pat(t - RL - 1)) begin
                    n_bad++; $display("FAIL b2b_data t=%0d: got %h want %h", t, a_rsp_rdata, pat(t - RL - 1)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        a_q.delete(); b_q.delete();
        for (int k = 0; k < 2; k++) begin
            a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'(8'h20 + k);
            #1;
            step();
        end
        idle_inputs();
        step();
        resetn = 1'b0;
        #1;
        n_cmp++; if ({a_rsp_valid, b_rsp_valid, bram_we, busy, bram_rd_addr, a_rsp_rdata} !== '0) begin
            n_bad++; $display("FAIL midrst_out: got %h want 0", {a_rsp_valid, b_rsp_valid, bram_we, busy, bram_rd_addr, a_rsp_rdata}); end
        step(); step();
        resetn = 1'b1;
        repeat (RL + 3) step();
        n_cmp++; if (a_q.size() != 0 || b_q.size() != 0) begin
            n_bad++; $display("FAIL midrst_rsp: got A=%0d B=%0d want 0/0", a_q.size(), b_q.size()); end
        a_req_valid = 1'b1; a_req_addr = 8'h30;
        b_req_valid = 1'b1; b_req_addr = 8'h31;
        #1;
        n_cmp++; if ({a_req_ready, b_req_ready} !== 2'b10) begin
            n_bad++; $display("FAIL midrst_ptr: got %b want 10", {a_req_ready, b_req_ready}); end
        step();
        a_req_valid = 1'b0;
        #1;
        n_cmp++; if ({a_req_ready, b_req_ready} !== 2'b01) begin
            n_bad++; $display("FAIL midrst_b: got %b want 01", {a_req_ready, b_req_ready}); end
        step();
        idle_inputs();
        repeat (RL + 3) step();
        n_cmp++; if (a_q.size() != 1 || b_q.size() != 1) begin
            n_bad++; $display("FAIL midrst_cnt: got A=%0d B=%0d want 1/1", a_q.size(), b_q.size()); end
        else begin
            n_cmp++; if ({a_q[0], b_q[0]} !== {pat(8'h30), pat(8'h31)}) begin
                n_bad++; $display("FAIL midrst_data: got %h want %h", {a_q[0], b_q[0]}, {pat(8'h30), pat(8'h31)}); end
        end
    endtask

    task automatic test_fairness();
        logic [7:0]  a_addr [3] = '{8'h40, 8'h41, 8'h42};
        logic [31:0] a_data [3] = '{32'h11, 32'h22, 32'h55};
        logic [7:0]  b_addr [3] = '{8'h50, 8'h51, 8'h52};
        logic [31:0] b_data [3] = '{32'h33, 32'h44, 32'h66};
        logic        b_on   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        exp_a  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int ia = 0, ib = 0;
        logic ga;
        logic [40:0] exp_w;
        a_q.delete(); b_q.delete();
        for (int c = 0; c < 5; c++) begin
            a_req_valid = 1'b1; a_req_we = 1'b1;
            a_req_addr = a_addr[ia > 2 ? 2 : ia]; a_req_wdata = a_data[ia > 2 ? 2 : ia];
            b_req_valid = b_on[c]; b_req_we = 1'b1;
            b_req_addr = b_addr[ib > 2 ? 2 : ib]; b_req_wdata = b_data[ib > 2 ? 2 : ib];
            #1;
            n_cmp++; if ({a_req_ready, b_req_ready} !== {exp_a[c], ~exp_a[c]}) begin
                n_bad++; $display("FAIL fair_grant c=%0d: got %b want %b", c, {a_req_ready, b_req_ready}, {exp_a[c], ~exp_a[c]}); end
            ga = a_req_ready;
            exp_w = exp_a[c] ? {1'b1, a_req_addr, a_req_wdata} : {1'b1, b_req_addr, b_req_wdata};
            step();
            $display("fair c=%0d grant=%s", c, ga ? "A" : "B");
            n_cmp++; if ({bram_we, bram_wr_addr, bram_wr_data} !== exp_w) begin
                n_bad++; $display("FAIL fair_write c=%0d: got %h want %h", c, {bram_we, bram_wr_addr, bram_wr_data}, exp_w); end
            if (ga) ia++; else ib++;
        end
        idle_inputs();
        b_req_valid = 1'b1; b_req_addr = 8'h41;
        #1;
        step();
        idle_inputs();
        repeat (RL + 3) step();
        n_cmp++; if (b_q.size() != 1 || a_q.size() != 0) begin
            n_bad++; $display("FAIL fair_rb_cnt: got A=%0d B=%0d want 0/1", a_q.size(), b_q.size()); end
        n_cmp++; if (b_rsp_rdata !== 32'h22) begin
            n_bad++; $display("FAIL fair_rb_data: got %h want 00000022", b_rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_write_read();
        test_raw_top();
        test_back_to_back();
        test_reset_mid();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
